// File: rtl/axi_tdd_ng_pkg.sv
// Shared types for the TDD engine; the frame monitor uses the state encoding below.
package axi_tdd_ng_pkg;

    typedef enum logic [1:0] {
        MON_IDLE    = 2'd0,
        MON_ARMED   = 2'd1,
        MON_RUNNING = 2'd2,
        MON_DONE    = 2'd3
    } mon_state_t;

endpackage

// File: rtl/axi_tdd_ng_frame_monitor_if.sv
// Configuration, observed TDD signals and published results of the frame monitor.
interface axi_tdd_ng_frame_monitor_if #(
    parameter int CHANNEL_COUNT     = 8,
    parameter int REGISTER_WIDTH    = 32,
    parameter int BURST_COUNT_WIDTH = 32
) ();
    import axi_tdd_ng_pkg::*;

    logic                                    mon_enable;
    logic [CHANNEL_COUNT-1:0]                mon_pol;
    logic [REGISTER_WIDTH-1:0]               mon_frame_length;
    logic [BURST_COUNT_WIDTH-1:0]            mon_burst_count;
    logic                                    sync_in;
    logic [CHANNEL_COUNT-1:0]                tdd_channel;

    mon_state_t                              mon_state;
    logic                                    res_valid;
    logic [BURST_COUNT_WIDTH-1:0]            res_frame;
    logic [CHANNEL_COUNT*REGISTER_WIDTH-1:0] res_on;
    logic [CHANNEL_COUNT*REGISTER_WIDTH-1:0] res_off;
    logic [CHANNEL_COUNT-1:0]                res_on_seen;
    logic [CHANNEL_COUNT-1:0]                res_off_seen;
    logic [CHANNEL_COUNT-1:0]                res_glitch;
    logic                                    err_resync;
    logic                                    err_cfg;

    // Driven by the monitor.
    modport slave (
        input  mon_enable, mon_pol, mon_frame_length, mon_burst_count, sync_in, tdd_channel,
        output mon_state, res_valid, res_frame, res_on, res_off,
               res_on_seen, res_off_seen, res_glitch, err_resync, err_cfg
    );

    // Driven by whoever configures and observes the monitor.
    modport master (
        output mon_enable, mon_pol, mon_frame_length, mon_burst_count, sync_in, tdd_channel,
        input  mon_state, res_valid, res_frame, res_on, res_off,
               res_on_seen, res_off_seen, res_glitch, err_resync, err_cfg
    );

endinterface

// File: rtl/axi_tdd_ng_frame_monitor_channel.sv
// One monitored channel: edge detect, first on/off timestamp capture, glitch flag and
// the published copy of those captures.
module axi_tdd_ng_frame_monitor_channel #(
    parameter int REGISTER_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      running,
    input  logic                      publish,
    input  logic                      discard,
    input  logic                      active,
    input  logic [REGISTER_WIDTH-1:0] counter,
    output logic [REGISTER_WIDTH-1:0] res_on,
    output logic [REGISTER_WIDTH-1:0] res_off,
    output logic                      res_on_seen,
    output logic                      res_off_seen,
    output logic                      res_glitch
);

    logic                      active_q;
    logic                      rise;
    logic                      fall;
    logic [REGISTER_WIDTH-1:0] cap_on_q;
    logic [REGISTER_WIDTH-1:0] cap_off_q;
    logic                      cap_on_seen_q;
    logic                      cap_off_seen_q;
    logic                      cap_glitch_q;
    logic [REGISTER_WIDTH-1:0] nxt_on;
    logic [REGISTER_WIDTH-1:0] nxt_off;
    logic                      nxt_on_seen;
    logic                      nxt_off_seen;
    logic                      nxt_glitch;

    // Edges in a resync cycle belong to the discarded partial frame.
    assign rise = running && !discard && active && !active_q;
    assign fall = running && !discard && !active && active_q;

    always_comb begin
        nxt_on       = cap_on_q;
        nxt_off      = cap_off_q;
        nxt_on_seen  = cap_on_seen_q;
        nxt_off_seen = cap_off_seen_q;
        nxt_glitch   = cap_glitch_q;
        if (rise) begin
            if (cap_on_seen_q) begin
                nxt_glitch = 1'b1;
            end else begin
                nxt_on      = counter;
                nxt_on_seen = 1'b1;
            end
        end
        if (fall) begin
            if (cap_off_seen_q) begin
                nxt_glitch = 1'b1;
            end else begin
                nxt_off      = counter;
                nxt_off_seen = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            active_q       <= 1'b0;
            cap_on_q       <= '0;
            cap_off_q      <= '0;
            cap_on_seen_q  <= 1'b0;
            cap_off_seen_q <= 1'b0;
            cap_glitch_q   <= 1'b0;
        end else begin
            active_q <= active;
            if (!running || discard || publish) begin
                cap_on_q       <= '0;
                cap_off_q      <= '0;
                cap_on_seen_q  <= 1'b0;
                cap_off_seen_q <= 1'b0;
                cap_glitch_q   <= 1'b0;
            end else begin
                cap_on_q       <= nxt_on;
                cap_off_q      <= nxt_off;
                cap_on_seen_q  <= nxt_on_seen;
                cap_off_seen_q <= nxt_off_seen;
                cap_glitch_q   <= nxt_glitch;
            end
        end
    end

    // Publishing takes the merged view so an edge on the closing cycle is included.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            res_on       <= '0;
            res_off      <= '0;
            res_on_seen  <= 1'b0;
            res_off_seen <= 1'b0;
            res_glitch   <= 1'b0;
        end else if (publish) begin
            res_on       <= nxt_on;
            res_off      <= nxt_off;
            res_on_seen  <= nxt_on_seen;
            res_off_seen <= nxt_off_seen;
            res_glitch   <= nxt_glitch;
        end
    end

endmodule

// File: rtl/axi_tdd_ng_frame_monitor.sv
// Receive-side TDD frame monitor: frame sequencing, cycle counter, frame index and
// publish strobe; per-channel capture lives in axi_tdd_ng_frame_monitor_channel.
//
// state       | meaning
// MON_IDLE    | disabled, waiting for mon_enable
// MON_ARMED   | enabled, waiting for sync_in with a non-zero frame length
// MON_RUNNING | counting frames and capturing channel edges
// MON_DONE    | requested burst published, holding until mon_enable drops
module axi_tdd_ng_frame_monitor
    import axi_tdd_ng_pkg::*;
#(
    parameter int CHANNEL_COUNT     = 8,
    parameter int REGISTER_WIDTH    = 32,
    parameter int BURST_COUNT_WIDTH = 32
) (
    input logic                       clk,
    input logic                       resetn,
    axi_tdd_ng_frame_monitor_if.slave mon
);

    mon_state_t                              state_q;
    mon_state_t                              state_d;
    logic [REGISTER_WIDTH-1:0]               counter_q;
    logic [BURST_COUNT_WIDTH-1:0]            frame_q;
    logic                                    res_valid_q;
    logic [BURST_COUNT_WIDTH-1:0]            res_frame_q;
    logic                                    err_resync_q;
    logic                                    err_cfg_q;

    logic                                    running;
    logic                                    frame_last;
    logic                                    publish;
    logic                                    resync;
    logic                                    arm_entry;
    logic                                    cfg_bad;
    logic                                    final_frame;

    logic [CHANNEL_COUNT*REGISTER_WIDTH-1:0] res_on_w;
    logic [CHANNEL_COUNT*REGISTER_WIDTH-1:0] res_off_w;
    logic [CHANNEL_COUNT-1:0]                res_on_seen_w;
    logic [CHANNEL_COUNT-1:0]                res_off_seen_w;
    logic [CHANNEL_COUNT-1:0]                res_glitch_w;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= MON_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!mon.mon_enable) begin
            state_d = MON_IDLE;
        end else begin
            case (state_q)
                MON_IDLE:    state_d = MON_ARMED;
                MON_ARMED:   if (mon.sync_in && !cfg_bad) state_d = MON_RUNNING;
                MON_RUNNING: if (publish && final_frame) state_d = MON_DONE;
                MON_DONE:    state_d = MON_DONE;
                default:     state_d = MON_IDLE;
            endcase
        end
    end

    // A sync landing on the closing cycle is the expected next frame start, not a resync.
    always_comb begin
        running     = 1'b0;
        frame_last  = 1'b0;
        publish     = 1'b0;
        resync      = 1'b0;
        arm_entry   = 1'b0;
        cfg_bad     = 1'b0;
        final_frame = 1'b0;

        running     = (state_q == MON_RUNNING);
        cfg_bad     = (mon.mon_frame_length == '0);
        frame_last  = running && (counter_q == mon.mon_frame_length - REGISTER_WIDTH'(1));
        publish     = frame_last && mon.mon_enable;
        resync      = running && mon.mon_enable && mon.sync_in && !frame_last;
        arm_entry   = (state_q == MON_IDLE) && mon.mon_enable;
        final_frame = (mon.mon_burst_count != '0) &&
                      (frame_q == mon.mon_burst_count - BURST_COUNT_WIDTH'(1));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            counter_q <= '0;
        end else if (!running || frame_last || resync) begin
            counter_q <= '0;
        end else begin
            counter_q <= counter_q + REGISTER_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            frame_q <= '0;
        end else if (arm_entry) begin
            frame_q <= '0;
        end else if (publish) begin
            frame_q <= frame_q + BURST_COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            res_valid_q  <= 1'b0;
            res_frame_q  <= '0;
            err_resync_q <= 1'b0;
            err_cfg_q    <= 1'b0;
        end else begin
            res_valid_q <= publish;
            if (publish) begin
                res_frame_q <= frame_q;
            end
            if (arm_entry) begin
                err_resync_q <= 1'b0;
            end else if (resync) begin
                err_resync_q <= 1'b1;
            end
            if (arm_entry) begin
                err_cfg_q <= 1'b0;
            end else if ((state_q == MON_ARMED) && mon.mon_enable && cfg_bad) begin
                err_cfg_q <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < CHANNEL_COUNT; i++) begin : g_ch
        axi_tdd_ng_frame_monitor_channel #(
            .REGISTER_WIDTH(REGISTER_WIDTH)
        ) u_ch (
            .clk         (clk),
            .resetn      (resetn),
            .running     (running),
            .publish     (publish),
            .discard     (resync),
            .active      (mon.tdd_channel[i] ^ mon.mon_pol[i]),
            .counter     (counter_q),
            .res_on      (res_on_w[i*REGISTER_WIDTH +: REGISTER_WIDTH]),
            .res_off     (res_off_w[i*REGISTER_WIDTH +: REGISTER_WIDTH]),
            .res_on_seen (res_on_seen_w[i]),
            .res_off_seen(res_off_seen_w[i]),
            .res_glitch  (res_glitch_w[i])
        );
    end

    assign mon.mon_state    = state_q;
    assign mon.res_valid    = res_valid_q;
    assign mon.res_frame    = res_frame_q;
    assign mon.res_on       = res_on_w;
    assign mon.res_off      = res_off_w;
    assign mon.res_on_seen  = res_on_seen_w;
    assign mon.res_off_seen = res_off_seen_w;
    assign mon.res_glitch   = res_glitch_w;
    assign mon.err_resync   = err_resync_q;
    assign mon.err_cfg      = err_cfg_q;

endmodule

// File: tb/tb_axi_tdd_ng_frame_monitor.sv
// Directed + randomized bench for axi_tdd_ng_frame_monitor; expected results come from
// edge lists computed over each frame's stimulus waveform.
module tb_axi_tdd_ng_frame_monitor;
    import axi_tdd_ng_pkg::*;

    localparam int CH   = 8;
    localparam int RW   = 32;
    localparam int BW   = 32;
    localparam int LMAX = 128;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    axi_tdd_ng_frame_monitor_if #(
        .CHANNEL_COUNT(CH), .REGISTER_WIDTH(RW), .BURST_COUNT_WIDTH(BW)
    ) mon_if ();

    axi_tdd_ng_frame_monitor #(
        .CHANNEL_COUNT(CH), .REGISTER_WIDTH(RW), .BURST_COUNT_WIDTH(BW)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .mon   (mon_if)
    );

    int errors = 0;
    int checks = 0;

    logic [CH-1:0] wave [LMAX];
    logic [CH-1:0] prev_lvl;
    logic [RW-1:0] exp_on  [CH];
    logic [RW-1:0] exp_off [CH];
    logic [CH-1:0] exp_on_seen;
    logic [CH-1:0] exp_off_seen;
    logic [CH-1:0] exp_glitch;
    logic [BW-1:0] exp_frame;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected frame result: list every activation/deactivation time in the frame.
    task automatic model(input int len);
        int  rises[$];
        int  falls[$];
        logic lvl, prv;
        for (int i = 0; i < CH; i++) begin
            rises.delete();
            falls.delete();
            prv = prev_lvl[i] ^ mon_if.mon_pol[i];
            for (int t = 0; t < len; t++) begin
                lvl = wave[t][i] ^ mon_if.mon_pol[i];
                if (lvl && !prv) rises.push_back(t);
                if (!lvl && prv) falls.push_back(t);
                prv = lvl;
            end
            exp_on_seen[i]  = (rises.size() > 0);
            exp_off_seen[i] = (falls.size() > 0);
            exp_on[i]       = (rises.size() > 0) ? RW'(rises[0]) : '0;
            exp_off[i]      = (falls.size() > 0) ? RW'(falls[0]) : '0;
            exp_glitch[i]   = (rises.size() > 1) || (falls.size() > 1);
        end
    endtask

    task automatic check_results();
        for (int i = 0; i < CH; i++) begin
            check($sformatf("on[%0d]", i),  mon_if.res_on[i*RW +: RW],  exp_on[i]);
            check($sformatf("off[%0d]", i), mon_if.res_off[i*RW +: RW], exp_off[i]);
        end
        check("on_seen",  mon_if.res_on_seen,  exp_on_seen);
        check("off_seen", mon_if.res_off_seen, exp_off_seen);
        check("glitch",   mon_if.res_glitch,   exp_glitch);
    endtask

    task automatic gen_wave(input int len);
        logic [CH-1:0] cur;
        cur = prev_lvl;
        for (int k = 0; k < len; k++) begin
            for (int i = 0; i < CH; i++)
                if ($urandom_range(7, 0) == 0) cur[i] = ~cur[i];
            wave[k] = cur;
        end
    endtask

    task automatic start_run(input int burst, input int len);
        mon_if.mon_enable       = 1'b0;
        step();
        mon_if.mon_burst_count  = BW'(burst);
        mon_if.mon_frame_length = RW'(len);
        mon_if.mon_enable       = 1'b1;
        step();
        check("armed", mon_if.mon_state, MON_ARMED);
        mon_if.tdd_channel = prev_lvl;
        mon_if.sync_in     = 1'b1;
        step();
        mon_if.sync_in = 1'b0;
        check("running", mon_if.mon_state, MON_RUNNING);
        exp_frame = '0;
    endtask

    task automatic drive_partial(input int n, output logic saw_valid);
        saw_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            mon_if.tdd_channel = wave[k];
            step();
            if (mon_if.res_valid !== 1'b0) saw_valid = 1'b1;
        end
    endtask

    task automatic play_frame(input int len, input bit sync_last);
        logic early;
        early = 1'b0;
        model(len);
        for (int k = 0; k < len; k++) begin
            mon_if.tdd_channel = wave[k];
            mon_if.sync_in     = sync_last && (k == len - 1);
            step();
            if (k < len - 1 && mon_if.res_valid !== 1'b0) early = 1'b1;
        end
        mon_if.sync_in = 1'b0;
        check("early_valid", early, 1'b0);
        check("res_valid", mon_if.res_valid, 1'b1);
        check("res_frame", mon_if.res_frame, exp_frame);
        check_results();
        prev_lvl  = wave[len-1];
        exp_frame = exp_frame + 1'b1;
    endtask

    initial begin
        logic          saw;
        logic [CH-1:0] r;
        logic [BW-1:0] kept_frame;

        mon_if.mon_enable       = 1'b0;
        mon_if.mon_pol          = '0;
        mon_if.mon_frame_length = '0;
        mon_if.mon_burst_count  = '0;
        mon_if.sync_in          = 1'b0;
        mon_if.tdd_channel      = '0;
        prev_lvl                = '0;
        exp_frame               = '0;

        // Reset state
        step();
        step();
        check("rst_state",  mon_if.mon_state, MON_IDLE);
        check("rst_valid",  mon_if.res_valid, 1'b0);
        check("rst_frame",  mon_if.res_frame, '0);
        check("rst_on",     (mon_if.res_on == '0), 1'b1);
        check("rst_off",    (mon_if.res_off == '0), 1'b1);
        check("rst_flags",  {mon_if.res_on_seen, mon_if.res_off_seen, mon_if.res_glitch}, '0);
        check("rst_errs",   {mon_if.err_resync, mon_if.err_cfg}, '0);
        resetn = 1'b1;
        step();

        // 1: three-frame burst, ch0 on 10..39
        for (int k = 0; k < 100; k++) wave[k] = (k >= 10 && k < 40) ? 8'h01 : 8'h00;
        prev_lvl = '0;
        start_run(3, 100);
        for (int f = 0; f < 3; f++) play_frame(100, 1'b0);
        check("t1_done", mon_if.mon_state, MON_DONE);
        check("t1_on0", mon_if.res_on[RW-1:0], 32'd10);
        check("t1_off0", mon_if.res_off[RW-1:0], 32'd40);
        drive_partial(20, saw);
        check("t1_hold_valid", saw, 1'b0);
        check("t1_hold_state", mon_if.mon_state, MON_DONE);

        // 2: inverted polarity on ch1, ch2 held active across the frame
        mon_if.mon_pol = 8'h02;
        for (int k = 0; k < 100; k++) wave[k] = (k >= 20 && k < 30) ? 8'h04 : 8'h06;
        prev_lvl = 8'h06;
        start_run(1, 100);
        play_frame(100, 1'b0);
        check("t2_on1",  mon_if.res_on[RW +: RW],  32'd20);
        check("t2_off1", mon_if.res_off[RW +: RW], 32'd30);
        check("t2_done", mon_if.mon_state, MON_DONE);

        // 3: ch3 double pulse then single; ch4 edges on both sides of the boundary
        mon_if.mon_pol = 8'h00;
        for (int k = 0; k < 100; k++)
            wave[k] = ((k == 5 || k == 50) ? 8'h08 : 8'h00) | ((k == 99) ? 8'h10 : 8'h00);
        prev_lvl = '0;
        start_run(2, 100);
        play_frame(100, 1'b0);
        check("t3_glitch_a", mon_if.res_glitch[3], 1'b1);
        check("t3_on4_last", mon_if.res_on[4*RW +: RW], 32'd99);
        for (int k = 0; k < 100; k++) wave[k] = (k == 5) ? 8'h08 : 8'h00;
        play_frame(100, 1'b0);
        check("t3_glitch_b", mon_if.res_glitch[3], 1'b0);
        check("t3_off4_zero", {mon_if.res_off_seen[4], mon_if.res_off[4*RW +: RW]}, {1'b1, 32'd0});

        // Random continuous run; one frame closes with a coincident sync
        mon_if.mon_pol = CH'($urandom);
        prev_lvl       = CH'($urandom);
        begin
            int len;
            len = $urandom_range(100, 20);
            start_run(0, len);
            for (int f = 0; f < 5; f++) begin
                gen_wave(len);
                play_frame(len, f == 2);
            end
        end
        check("rnd_no_resync", mon_if.err_resync, 1'b0);
        check("rnd_running", mon_if.mon_state, MON_RUNNING);

        // 4: resync at counter 37 discards the partial frame
        prev_lvl = CH'($urandom);
        start_run(0, 100);
        gen_wave(100);
        play_frame(100, 1'b0);
        gen_wave(37);
        drive_partial(37, saw);
        r = CH'($urandom);
        mon_if.tdd_channel = r;
        mon_if.sync_in     = 1'b1;
        step();
        mon_if.sync_in = 1'b0;
        check("t4_partial_valid", saw | mon_if.res_valid, 1'b0);
        check("t4_err_resync", mon_if.err_resync, 1'b1);
        prev_lvl = r;
        gen_wave(100);
        play_frame(100, 1'b0);
        check("t4_frame_kept", mon_if.res_frame, 1);

        // Enable dropped mid-frame: results keep the last published set
        kept_frame = mon_if.res_frame;
        prev_lvl = wave[99];
        start_run(0, 100);
        gen_wave(30);
        drive_partial(30, saw);
        mon_if.mon_enable = 1'b0;
        step();
        check("drop_state", mon_if.mon_state, MON_IDLE);
        drive_partial(1, saw);
        for (int k = 0; k < 120; k++) begin
            step();
            if (mon_if.res_valid !== 1'b0) saw = 1'b1;
        end
        check("drop_no_valid", saw, 1'b0);
        check("drop_frame", mon_if.res_frame, kept_frame);
        check_results();

        // 5: zero frame length
        mon_if.mon_frame_length = '0;
        mon_if.mon_enable       = 1'b1;
        step();
        check("t5_armed", mon_if.mon_state, MON_ARMED);
        mon_if.sync_in = 1'b1;
        step();
        mon_if.sync_in = 1'b0;
        step();
        check("t5_stay_armed", mon_if.mon_state, MON_ARMED);
        check("t5_err_cfg", mon_if.err_cfg, 1'b1);
        mon_if.mon_enable = 1'b0;
        step();
        check("t5_idle", mon_if.mon_state, MON_IDLE);
        check("t5_err_sticky", mon_if.err_cfg, 1'b1);
        mon_if.mon_frame_length = 32'd100;
        mon_if.mon_enable       = 1'b1;
        step();
        check("t5_rearm", mon_if.mon_state, MON_ARMED);
        check("t5_err_clr", mon_if.err_cfg, 1'b0);

        // 6: async reset mid-frame
        prev_lvl = '0;
        for (int k = 0; k < 100; k++) wave[k] = (k >= 10) ? 8'hFF : 8'h00;
        start_run(0, 100);
        drive_partial(40, saw);
        resetn = 1'b0;
        #1;
        check("t6_state", mon_if.mon_state, MON_IDLE);
        check("t6_valid", mon_if.res_valid, 1'b0);
        check("t6_frame", mon_if.res_frame, '0);
        check("t6_on",    (mon_if.res_on == '0), 1'b1);
        check("t6_off",   (mon_if.res_off == '0), 1'b1);
        check("t6_flags", {mon_if.res_on_seen, mon_if.res_off_seen, mon_if.res_glitch}, '0);
        check("t6_errs",  {mon_if.err_resync, mon_if.err_cfg}, '0);
        step();
        resetn = 1'b1;
        saw = 1'b0;
        for (int k = 0; k < 150; k++) begin
            step();
            if (mon_if.res_valid !== 1'b0) saw = 1'b1;
        end
        check("t6_no_valid", saw, 1'b0);
        check("t6_armed", mon_if.mon_state, MON_ARMED);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
